// File: rtl/tone_generator.sv
// -----------------------------------------------------------------------------
// tone_generator
//
// Burst sine-tone source. A second-order recursive oscillator (a Goertzel
// resonator run with no input) produces y[n] = A*sin(n*w) for a programmed
// number of samples. Output is a signed sample stream with valid/ready flow
// control.
//
// Ports:
//   i_clk    - clock, all logic on the rising edge
//   i_rst    - synchronous active-high reset
//   i_start  - one-cycle burst request, ignored while o_busy=1
//   i_coef   - signed 2*cos(w), Q(COEF_WIDTH-COEF_FRAC).COEF_FRAC
//   i_seed   - signed A*sin(w), i.e. y[1]
//   i_len    - unsigned number of samples in the burst
//   i_ready  - downstream accepts the current sample
//   o_valid  - o_data holds a sample
//   o_data   - signed sample y[n]
//   o_busy   - burst in progress
//   o_done   - one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
module tone_generator #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [COEF_WIDTH-1:0] i_coef,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    // Full-precision product width; the difference is carried one bit wider.
    localparam int PW = COEF_WIDTH + DATA_WIDTH;

    // Saturation bounds expressed at the (PW+1)-bit difference width.
    localparam logic signed [PW:0] SAT_MAX = {{(PW + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [DATA_WIDTH-1:0] seed;
    logic        [LEN_WIDTH-1:0]  len;
    logic signed [DATA_WIDTH-1:0] s1;      // current sample y[n]
    logic signed [DATA_WIDTH-1:0] s2;      // previous sample y[n-1]
    logic        [LEN_WIDTH-1:0]  cnt;     // index of the sample on o_data
    logic        [LEN_WIDTH-1:0]  cnt_inc;
    logic                         done;
    logic                         done_next;
    logic                         accept;
    logic                         handshake;
    logic                         last;

    logic signed [PW-1:0]         coef_ext;
    logic signed [PW-1:0]         s1_ext;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         prod_sh;
    logic signed [PW:0]           prod_sh_ext;
    logic signed [PW:0]           s2_ext;
    logic signed [PW:0]           diff;
    logic signed [DATA_WIDTH-1:0] next_sample;

    assign handshake = (state == RUN) && i_ready;
    assign cnt_inc   = cnt + LEN_WIDTH'(1);
    assign last      = (cnt_inc == len);

    // Recurrence: next = sat(((coef * s1) >>> COEF_FRAC) - s2).
    // Operands are sign-extended to the full product width so the multiply is
    // exact; the arithmetic shift floors toward -inf with no rounding.
    always_comb begin
        coef_ext    = {{DATA_WIDTH{coef[COEF_WIDTH-1]}}, coef};
        s1_ext      = {{COEF_WIDTH{s1[DATA_WIDTH-1]}}, s1};
        prod        = coef_ext * s1_ext;
        prod_sh     = prod >>> COEF_FRAC;
        prod_sh_ext = {prod_sh[PW-1], prod_sh};
        s2_ext      = {{(PW + 1 - DATA_WIDTH){s2[DATA_WIDTH-1]}}, s2};
        diff        = prod_sh_ext - s2_ext;
        if (diff > SAT_MAX) begin
            next_sample = SAT_MAX[DATA_WIDTH-1:0];
        end else if (diff < SAT_MIN) begin
            next_sample = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            next_sample = diff[DATA_WIDTH-1:0];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value unassigned (latch).
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    accept = 1'b1;
                    if (i_len == '0) begin
                        // Empty burst: completes immediately, no samples.
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // A start here is dropped, including on the final handshake.
                if (handshake && last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            done  <= 1'b0;
            coef  <= '0;
            seed  <= '0;
            len   <= '0;
            s1    <= '0;
            s2    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (accept) begin
                coef <= i_coef;
                seed <= i_seed;
                len  <= i_len;
                s1   <= '0;   // y[0]
                s2   <= '0;
                cnt  <= '0;
            end else if (handshake) begin
                cnt <= cnt_inc;
                if (!last) begin
                    if (cnt == '0) begin
                        // y[1] is loaded directly; the recurrence starts at y[2].
                        s1 <= seed;
                        s2 <= '0;
                    end else begin
                        s1 <= next_sample;
                        s2 <= s1;
                    end
                end
            end
        end
    end

    assign o_valid = (state == RUN);
    assign o_busy  = (state == RUN);
    assign o_data  = o_valid ? s1 : '0;
    assign o_done  = done;

endmodule

// File: tb/tb_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_tone_generator
//
// Self-checking bench for tone_generator. Expected samples come from an
// independent integer model of the oscillator and are queued when a burst is
// started; a monitor pops and compares them at each handshake.
// -----------------------------------------------------------------------------
module tb_tone_generator;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int CF = 14;
    localparam int LW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [CW-1:0] i_coef;
    logic [DW-1:0] i_seed;
    logic [LW-1:0] i_len;
    logic          i_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic          o_done;

    tone_generator #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .COEF_FRAC  (CF),
        .LEN_WIDTH  (LW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_coef  (i_coef),
        .i_seed  (i_seed),
        .i_len   (i_len),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   cyc = 0;
    int                   hs_cnt = 0;
    int                   last_hs_edge = -1;
    logic signed [DW-1:0] exp_q[$];
    logic                 stall_prev = 1'b0;
    logic [DW-1:0]        prev_data = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Floor of p / 2^CF, written with division so it does not mirror a shift.
    function automatic longint floor_scale(input longint p);
        longint d;
        longint q;
        d = longint'(1) << CF;
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic signed [DW-1:0] sat(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return DW'(v);
    endfunction

    task automatic push_model(input int coef, input int seed, input int n);
        longint ym1;
        longint ym2;
        longint y;
        ym1 = 0;
        ym2 = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0)      y = 0;
            else if (k == 1) y = seed;
            else             y = longint'(sat(floor_scale(longint'(coef) * ym1) - ym2));
            exp_q.push_back(DW'(y));
            ym2 = ym1;
            ym1 = y;
        end
    endtask

    // Scoreboard side: compare each handshaken sample, and check that a
    // stalled sample holds until it is taken.
    always @(negedge i_clk) begin
        if (stall_prev) check("stall_hold", 32'($signed(o_data)), 32'($signed(prev_data)));
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'(o_valid), 0);
            end else begin
                check("sample", 32'($signed(o_data)), 32'(exp_q.pop_front()));
            end
            hs_cnt++;
            last_hs_edge = cyc + 1;
        end
        stall_prev = (o_valid === 1'b1) && (i_ready === 1'b0);
        prev_data  = o_data;
    end

    // Drives a start for one edge, queues n_push expected samples, then
    // scrambles the configuration inputs, which must have no further effect.
    task automatic do_start(input int coef, input int seed, input int len, input int n_push);
        i_coef  = CW'(coef);
        i_seed  = DW'(seed);
        i_len   = LW'(len);
        i_start = 1'b1;
        hs_cnt  = 0;
        push_model(coef, seed, n_push);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_coef  = CW'($urandom);
        i_seed  = DW'($urandom);
        i_len   = LW'($urandom);
        if (len > 0) begin
            check("start_valid", 32'(o_valid), 1);
            check("start_busy", 32'(o_busy), 1);
            check("start_data", 32'($signed(o_data)), 0);
        end
    endtask

    // Runs a burst to completion with a repeating ready pattern, optionally
    // holding i_start (with a different coef) for the whole burst.
    task automatic run_to_done(input logic [3:0] pat, input logic hold_start, input int exp_hs);
        int seen;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            if (o_done === 1'b1) begin
                seen = 1;
                break;
            end
            i_ready = pat[k % 4];
            i_start = hold_start;
            if (hold_start) i_coef = CW'(16'h1234);
            @(posedge i_clk);
            #1;
        end
        i_start = 1'b0;
        check("done_seen", seen, 1);
        check("done_timing", cyc, last_hs_edge);
        check("end_busy", 32'(o_busy), 0);
        check("end_valid", 32'(o_valid), 0);
        check("handshakes", hs_cnt, exp_hs);
        check("queue_empty", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
        check("done_one_cycle", 32'(o_done), 0);
        check("idle_after_done", 32'(o_busy), 0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_coef  = '0;
        i_seed  = '0;
        i_len   = '0;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'($signed(o_data)), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // w = pi/2: 0, 1000, 0, -1000, 0, 1000
        do_start(0, 1000, 6, 6);
        run_to_done(4'b1111, 1'b0, 6);

        // w = pi: negative coefficient and floor shift
        do_start(-32768, 100, 5, 5);
        run_to_done(4'b1111, 1'b0, 5);

        // Positive and negative saturation
        do_start(32767, 20000, 3, 3);
        run_to_done(4'b1111, 1'b0, 3);
        do_start(32767, -20000, 3, 3);
        run_to_done(4'b1111, 1'b0, 3);

        // Backpressure with ready 1,0,0,1,...
        do_start(0, 1000, 6, 6);
        run_to_done(4'b1001, 1'b0, 6);

        // Empty burst: done pulse, never valid
        i_ready = 1'b1;
        do_start(0, 1000, 0, 0);
        check("len0_done", 32'(o_done), 1);
        check("len0_busy", 32'(o_busy), 0);
        check("len0_valid", 32'(o_valid), 0);
        @(posedge i_clk);
        #1;
        check("len0_done_one_cycle", 32'(o_done), 0);
        check("len0_valid_after", 32'(o_valid), 0);

        // Start held through the whole burst (incl. final handshake) is ignored
        do_start(0, 1000, 6, 6);
        run_to_done(4'b1111, 1'b1, 6);
        do_start(-32768, 100, 5, 5);
        run_to_done(4'b1011, 1'b1, 5);

        // Reset on the 3rd sample aborts with no done pulse
        do_start(0, 1000, 6, 3);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("abort_valid", 32'(o_valid), 0);
        check("abort_data", 32'($signed(o_data)), 0);
        check("abort_busy", 32'(o_busy), 0);
        check("abort_done", 32'(o_done), 0);
        check("abort_handshakes", hs_cnt, 3);
        check("abort_queue_empty", exp_q.size(), 0);
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            check("abort_no_done", 32'(o_done), 0);
        end

        // Fresh start after the abort restarts from y[0]
        do_start(0, 1000, 6, 6);
        run_to_done(4'b1111, 1'b0, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
